// File: rtl/atomik_ingress_framer.sv
// atomik_ingress_framer: packs a valid/ready byte stream little-endian into 32-bit words and
// issues each buffered frame to the ATOMiK core as one gap-free core_valid burst.
module atomik_ingress_framer #(
   parameter int         FIFO_DEPTH = 16,
   parameter int         GAP_CYCLES = 1,
   parameter logic [7:0] PAD_BYTE   = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_byte,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [31:0] core_data,
   output logic        core_valid,
   output logic [15:0] frames_sent,
   output logic        oversize,
   output logic        busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

   state_t        state, state_nx;
   logic [GW-1:0] gap_cnt, gap_nx;
   logic [1:0]    lane;
   logic [31:0]   hold, pack;
   logic [32:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, pending;
   logic          accept, push, push_last, pop, head_last, valid_nx, set_oversize;

   assign s_ready   = rst_n && (count < DEPTH);
   assign accept    = s_valid && s_ready;
   assign push      = accept && (lane == 2'd3 || s_last);
   assign push_last = push && s_last;
   assign head_last = mem[rd_ptr][32];
   assign busy      = (state != IDLE) || (count != '0) || (lane != 2'd0);

   // Lanes below the current one come from the hold register, lanes above get padding.
   for (genvar g = 0; g < 4; g++) begin : lanes
      assign pack[8*g +: 8] = (lane > 2'(g)) ? hold[8*g +: 8] : (lane == 2'(g)) ? s_byte : PAD_BYTE;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {push_last, pack};
   end

   // A frame closing on this very edge counts as pending, so its burst starts one edge later.
   always_comb begin
      state_nx     = state;
      gap_nx       = gap_cnt;
      valid_nx     = 1'b0;
      pop          = 1'b0;
      set_oversize = 1'b0;
      case (state)
         IDLE: begin
            set_oversize = (pending == '0) && !push_last && (count == DEPTH);
            state_nx     = (pending != '0 || push_last || set_oversize) ? BURST : IDLE;
         end
         BURST: begin
            pop      = (count != '0);
            valid_nx = pop;
            state_nx = (pop && head_last) ? GAP : BURST;
            gap_nx   = GAP_LOAD;
         end
         GAP: begin
            state_nx = (gap_cnt == '0) ? IDLE : GAP;
            gap_nx   = gap_cnt - GW'(1);
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         gap_cnt     <= '0;
         lane        <= 2'd0;
         hold        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         pending     <= '0;
         core_data   <= '0;
         core_valid  <= 1'b0;
         frames_sent <= '0;
         oversize    <= 1'b0;
      end else begin
         state      <= state_nx;
         gap_cnt    <= gap_nx;
         core_valid <= valid_nx;
         if (accept) begin
            hold[8*lane +: 8] <= s_byte;
            lane              <= push ? 2'd0 : lane + 2'd1;
         end
         if (pop) core_data <= mem[rd_ptr][31:0];
         if (pop && head_last) frames_sent <= frames_sent + 16'd1;
         if (set_oversize) oversize <= 1'b1;
         wr_ptr  <= wr_ptr + AW'(push);
         rd_ptr  <= rd_ptr + AW'(pop);
         count   <= count + CW'(push) - CW'(pop);
         pending <= pending + CW'(push_last) - CW'(pop && head_last);
      end
   end
endmodule

// File: tb/tb_atomik_ingress_framer.sv
// tb_atomik_ingress_framer: randomized and directed checks of the framer against a byte-level
// reference model; a second instance covers pad override and longer idle gaps.
module tb_atomik_ingress_framer;
   localparam int GAP1 = 1;
   localparam int GAP2 = 4;

   typedef struct {
      logic [31:0] b;
      int          n;
      logic        last;
   } ent_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [7:0]  s_byte = 8'h00;
   logic        s_valid = 1'b0, s_last = 1'b0;
   logic        v1, v2, s_ready1, s_ready2, core_valid1, core_valid2;
   logic        oversize1, oversize2, busy1, busy2;
   logic [31:0] core_data1, core_data2;
   logic [15:0] frames_sent1, frames_sent2;

   int          checks = 0, failures = 0;
   int          cyc = 0, last_acc = 0, nb = 0, mframes = 0, low = 100;
   logic [31:0] part = '0, last_w = '0;
   bit          rst_edge = 1'b0, live = 1'b0, allow_holes = 1'b0, saw_nr = 1'b0;
   bit          prev_v = 1'b0, prev_l = 1'b1;
   ent_t        expq[$];
   logic [31:0] got1[$], got2[$];
   int          cyc1[$], cyc2[$];

   // Both instances accept a byte only when both are ready, keeping their inputs identical.
   assign v1 = s_valid && s_ready2;
   assign v2 = s_valid && s_ready1;

   atomik_ingress_framer #(.FIFO_DEPTH(16), .GAP_CYCLES(GAP1), .PAD_BYTE(8'h00)) dut1 (
      .clk(clk), .rst_n(rst_n), .s_byte(s_byte), .s_valid(v1), .s_last(s_last),
      .s_ready(s_ready1), .core_data(core_data1), .core_valid(core_valid1),
      .frames_sent(frames_sent1), .oversize(oversize1), .busy(busy1));

   atomik_ingress_framer #(.FIFO_DEPTH(16), .GAP_CYCLES(GAP2), .PAD_BYTE(8'hFF)) dut2 (
      .clk(clk), .rst_n(rst_n), .s_byte(s_byte), .s_valid(v2), .s_last(s_last),
      .s_ready(s_ready2), .core_data(core_data2), .core_valid(core_valid2),
      .frames_sent(frames_sent2), .oversize(oversize2), .busy(busy2));

   always #5 clk = ~clk;

   task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
   endtask

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      if (ok) checks++;
      else fail(name, act, req);
   endtask

   function automatic logic [31:0] pk(input logic [31:0] b, input int n, input logic [7:0] pad);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = (k < n) ? b[8*k +: 8] : pad;
      return r;
   endfunction

   // Reference model: accepted bytes grouped into words of up to four, closed early by last.
   always @(posedge clk) begin
      cyc++;
      rst_edge = !rst_n;
      if (!rst_n) begin
         expq.delete();
         nb   = 0;
         part = '0;
         live = 1'b1;
      end else if (s_valid && s_ready1 && s_ready2) begin
         part[8*nb +: 8] = s_byte;
         nb++;
         if (s_last) last_acc = cyc;
         if (nb == 4 || s_last) begin
            expq.push_back('{part, nb, s_last});
            nb   = 0;
            part = '0;
         end
      end
   end

   always @(negedge clk) begin
      ent_t        e;
      logic [31:0] w;
      if (rst_edge) begin
         chk(!core_valid1 && core_data1 == '0 && frames_sent1 == '0 && !oversize1 && !busy1,
             "reset_state", {core_valid1, oversize1, busy1, frames_sent1[12:0], core_data1[15:0]}, 32'h0);
         mframes = 0;
         prev_v  = 1'b0;
         prev_l  = 1'b1;
         low     = 100;
         last_w  = '0;
      end else if (live) begin
         if (core_valid1) begin
            if (expq.size() == 0) fail("extra_word", core_data1, 32'h0);
            else begin
               e = expq.pop_front();
               w = pk(e.b, e.n, 8'h00);
               chk(core_data1 == w, "word", core_data1, w);
               if (!prev_v && prev_l) chk(low >= GAP1 + 1, "gap_len", low, GAP1 + 1);
               if (e.last) mframes++;
               prev_l = e.last;
               last_w = w;
            end
            low = 0;
         end else begin
            if (prev_v && !prev_l && !allow_holes) fail("burst_hole", 32'h0, 32'h1);
            chk(core_data1 == last_w, "data_hold", core_data1, last_w);
            low++;
         end
         chk(frames_sent1 == 16'(mframes), "frames_sent", 32'(frames_sent1), mframes);
         prev_v = core_valid1;
      end
   end

   always @(negedge clk) begin
      if (core_valid1) begin got1.push_back(core_data1); cyc1.push_back(cyc); end
      if (core_valid2) begin got2.push_back(core_data2); cyc2.push_back(cyc); end
      if (s_valid && !s_ready1) saw_nr = 1'b1;
   end

   task automatic send(input logic [7:0] b, input logic l);
      int   t = 0;
      logic acc;
      s_byte  = b;
      s_last  = l;
      s_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = s_ready1 && s_ready2;
         @(posedge clk);
         t++;
      end while (!acc && t < 1000);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!acc) fail("send_timeout", t, 32'h0);
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while ((busy1 || busy2) && t < 1000);
      chk(!busy1 && !busy2, "idle_timeout", t, 32'h0);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_caps();
      got1.delete(); got2.delete(); cyc1.delete(); cyc2.delete();
   endtask

   initial begin
      int t, len;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: two-word frame, latency and back-to-back words
      clear_caps();
      for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
      wait_idle();
      chk(got1.size() == 2, "t1_count", got1.size(), 2);
      chk(got1[0] == 32'h04030201, "t1_w0", got1[0], 32'h04030201);
      chk(got1[1] == 32'h08070605, "t1_w1", got1[1], 32'h08070605);
      chk(cyc1[0] == last_acc + 1, "t1_latency", cyc1[0], last_acc + 1);
      chk(cyc1[1] == cyc1[0] + 1, "t1_consecutive", cyc1[1], cyc1[0] + 1);
      chk(frames_sent1 == 16'd1, "t1_frames", 32'(frames_sent1), 1);

      // 2: partial final word padded with PAD_BYTE
      clear_caps();
      send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 1);
      wait_idle();
      chk(got1.size() == 2 && got1[0] == 32'hDDCCBBAA, "t2_w0", got1[0], 32'hDDCCBBAA);
      chk(got1[1] == 32'h000000EE, "t2_pad00", got1[1], 32'h000000EE);
      chk(got2.size() == 2 && got2[0] == 32'hDDCCBBAA, "t2_w0_ff", got2[0], 32'hDDCCBBAA);
      chk(got2[1] == 32'hFFFFFFEE, "t2_padff", got2[1], 32'hFFFFFFEE);

      // 3: two single-word frames streamed back-to-back
      clear_caps();
      for (int i = 0; i < 8; i++) send(8'(8'h10 + i), i == 3 || i == 7);
      wait_idle();
      chk(cyc2.size() == 2, "t3_pulses", cyc2.size(), 2);
      chk(cyc2[1] - cyc2[0] == GAP2 + 2, "t3_gap_exact", cyc2[1] - cyc2[0], GAP2 + 2);
      chk(cyc1.size() == 2 && cyc1[1] == last_acc + 1, "t3_latency", cyc1[1], last_acc + 1);
      chk(got2[1] == 32'h17161514, "t3_w1", got2[1], 32'h17161514);
      chk(frames_sent1 == 16'd4 && frames_sent2 == 16'd4, "t3_frames", 32'(frames_sent2), 4);

      // 4: frame longer than the FIFO is split and flagged
      clear_caps();
      allow_holes = 1'b1;
      saw_nr      = 1'b0;
      for (int i = 0; i < 64; i++) send(8'(i), 0);
      send(8'hAB, 1);
      wait_idle();
      chk(saw_nr, "t4_not_ready", 32'(saw_nr), 1);
      chk(oversize1 && oversize2, "t4_oversize", {oversize1, oversize2}, 2'b11);
      chk(got1.size() == 17, "t4_count", got1.size(), 17);
      chk(got1[0] == 32'h03020100, "t4_w0", got1[0], 32'h03020100);
      chk(got1[15] == 32'h3F3E3D3C, "t4_w15", got1[15], 32'h3F3E3D3C);
      chk(got1[16] == 32'h000000AB, "t4_w16", got1[16], 32'h000000AB);
      chk(s_ready1, "t4_ready_back", 32'(s_ready1), 1);
      chk(frames_sent1 == 16'd5, "t4_frames", 32'(frames_sent1), 5);

      // 5: reset in the middle of a three-word burst
      for (int i = 0; i < 12; i++) send(8'(8'hA0 + i), i == 11);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!core_valid1 && t < 200);
      if (!core_valid1) fail("t5_burst_timeout", t, 32'h0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk(!core_valid1 && !busy1 && frames_sent1 == '0, "t5_reset", {core_valid1, busy1, frames_sent1}, 0);
      chk(!core_valid2 && !busy2 && !oversize2 && frames_sent2 == '0, "t5_reset2", {core_valid2, busy2, frames_sent2}, 0);
      allow_holes = 1'b0;
      @(posedge clk);
      #1;
      clear_caps();
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
      wait_idle();
      chk(got1.size() == 1 && got1[0] == 32'h44332211, "t5_clean", got1[0], 32'h44332211);
      chk(frames_sent1 == 16'd1, "t5_frames", 32'(frames_sent1), 1);

      // 6: random frames of up to ten words with random idle gaps
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 2) == 0) begin
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
            send(8'($urandom), i == len - 1);
         end
      end
      wait_idle();
      chk(expq.size() == 0, "t6_drained", expq.size(), 0);
      chk(frames_sent1 == 16'd41, "t6_frames", 32'(frames_sent1), 41);
      chk(!oversize1, "t6_no_oversize", 32'(oversize1), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
